// File: rtl/left_shift.sv
// left_shift: clocked logical left-shift stage with valid/ready handshakes on
// both sides. The shift is applied when a token is captured, and a small
// in-order buffer holds the shifted tokens. The buffer is a shift register:
// entry 0 is always the head, so out_data comes straight from a register.
module left_shift #(
  parameter int WIDTH = 11,
  parameter int SHIFT = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [WIDTH-1:0] shiftedData;
  logic [CW-1:0]    wrIdx;
  logic             push;
  logic             pop;

  // Logical shift: MSBs fall off the top, zeros fill the bottom.
  assign shiftedData = in_data << SHIFT;

  // Ready depends only on occupancy, and is held low while reset is asserted.
  assign in_ready  = rst_n && (int'(count_q) < DEPTH);
  assign out_valid = (count_q != '0);
  assign out_data  = mem_q[0];

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // A token pushed together with a pop lands one slot lower, because the
  // head moves out on the same edge.
  assign wrIdx = pop ? (count_q - CW'(1)) : count_q;

  // Next-state logic: shift the buffer on pop, then drop a new token into
  // the first free slot. On a pop that empties the buffer the head slot is
  // left untouched, so out_data keeps showing the last token sent.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (i + 1 < int'(count_q)) begin
          mem_d[i] = mem_q[i+1];
        end
      end
    end
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wrIdx) begin
          mem_d[i] = shiftedData;
        end
      end
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers: reset empties the buffer and clears all stored data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: tb/tb_left_shift.sv
// Self-checking bench for left_shift (WIDTH=11, SHIFT=1, DEPTH=2).
module tb_left_shift;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] out_data;

  int compared;
  int mismatched;

  left_shift #(.WIDTH(11), .SHIFT(1), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: doubling the value modulo 2^11 is a one-bit logical left shift.
  function automatic logic [10:0] refShift(input logic [10:0] x);
    int v;
    v = int'(x) * 2;
    return 11'(v % 2048);
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    compared++;
    if (out_valid !== 1'b0 || out_data !== 11'd0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_por: valid=%b data=%h ready=%b want 0/000/0", out_valid, out_data, in_ready);
    end
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", in_ready);
    end
    // Fill the buffer with a stalled output, then reset mid-stream.
    in_valid = 1'b1; in_data = 11'h155;
    tick();
    in_data = 11'h2AA;
    tick();
    in_valid = 1'b0;
    compared++;
    if (out_valid !== 1'b1 || out_data !== refShift(11'h155)) begin
      mismatched++;
      $display("[TB] FAIL reset_prefill: valid=%b data=%h want 1/%h", out_valid, out_data, refShift(11'h155));
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || out_data !== 11'd0 || in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_midstream: valid=%b data=%h ready=%b want 0/000/0", out_valid, out_data, in_ready);
    end
    tick();
    rst_n = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_after: ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    tick(); tick();
    compared++;
    if (out_valid !== 1'b0 || out_data !== 11'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_no_stale: valid=%b data=%h want 0/000", out_valid, out_data);
    end
  endtask

  // Send one token into an empty block and check it one cycle later.
  task automatic test_single(input string name, input logic [10:0] x, input logic [10:0] want);
    out_ready = 1'b1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_idle: ready=%b valid=%b want 1/0", name, in_ready, out_valid);
    end
    in_valid = 1'b1; in_data = x;
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s_no_bypass: valid=%b want 0", name, out_valid);
    end
    tick();
    in_valid = 1'b0; in_data = 11'h3C3;
    compared++;
    if (out_valid !== 1'b1 || out_data !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: valid=%b data=%h want 1/%h", name, out_valid, out_data, want);
    end
    tick();
    compared++;
    if (out_valid !== 1'b0 || out_data !== want) begin
      mismatched++;
      $display("[TB] FAIL %s_hold_empty: valid=%b data=%h want 0/%h", name, out_valid, out_data, want);
    end
  endtask

  task automatic test_back_pressure();
    logic [10:0] a, b;
    a = 11'($urandom); b = 11'($urandom);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b1; in_data = 11'h7FF;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_full_ready: got %b want 0", in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_data !== refShift(a) || in_ready !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_stall%0d: valid=%b data=%h ready=%b want 1/%h/0", i, out_valid, out_data, in_ready, refShift(a));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    compared++;
    if (out_valid !== 1'b1 || out_data !== refShift(b)) begin
      mismatched++;
      $display("[TB] FAIL bp_second: valid=%b data=%h want 1/%h", out_valid, out_data, refShift(b));
    end
    tick();
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_drain: valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_throughput();
    logic [10:0] tok [16];
    for (int i = 0; i < 16; i++) tok[i] = 11'($urandom);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_data = tok[i];
      #1;
      compared++;
      if (in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL tput_ready%0d: got %b want 1", i, in_ready);
      end
      tick();
      compared++;
      if (out_valid !== 1'b1 || out_data !== refShift(tok[i])) begin
        mismatched++;
        $display("[TB] FAIL tput%0d: valid=%b data=%h want 1/%h", i, out_valid, out_data, refShift(tok[i]));
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [10:0] q[$];
    logic [10:0] lastOut;
    logic        inFire, outFire;
    logic [10:0] d;
    lastOut = out_data;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      d = 11'($urandom);
      in_data = d;
      #1;
      compared++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) ||
          out_data !== ((q.size() > 0) ? q[0] : lastOut)) begin
        mismatched++;
        $display("[TB] FAIL rand%0d: valid=%b ready=%b data=%h want %b/%b/%h", cyc, out_valid, in_ready, out_data,
                 (q.size() > 0), (q.size() < 2), ((q.size() > 0) ? q[0] : lastOut));
      end
      inFire  = in_valid && (q.size() < 2);
      outFire = out_ready && (q.size() > 0);
      tick();
      if (outFire) lastOut = q.pop_front();
      if (inFire) q.push_back(refShift(d));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_single("basic", 11'b01010100111, 11'b10101001110);
    test_single("msb_loss", 11'b11011100100, 11'b10111001000);
    test_single("edge_7ff", 11'h7FF, 11'h7FE);
    test_single("edge_400", 11'h400, 11'h000);
    test_single("edge_000", 11'h000, 11'h000);
    test_back_pressure();
    test_throughput();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
